// File: rtl/mem_ctr_burst_if.sv
// Cache-side command/data bus of the burst memory controller: split in/out ports.
// master = cache controller, slave = mem_ctr_burst.
interface mem_ctr_burst_if #(
    parameter int LINE_ADDR_W = 10,
    parameter int BUS_BYTES   = 2
);
    logic [1:0]             C2_IN;
    logic [LINE_ADDR_W-1:0] A2_IN;
    logic [8*BUS_BYTES-1:0] D2_IN;
    logic [1:0]             C2_OUT;
    logic [8*BUS_BYTES-1:0] D2_OUT;
    logic                   BUSY;

    modport master (
        output C2_IN, A2_IN, D2_IN,
        input  C2_OUT, D2_OUT, BUSY
    );

    modport slave (
        input  C2_IN, A2_IN, D2_IN,
        output C2_OUT, D2_OUT, BUSY
    );
endinterface

// File: rtl/mem_ctr_burst.sv
// Whole-line burst memory controller; optional MEM_STATS_EN adds RD/WR/DROP counters.
// Latency: first RESPONSE beat MEM_DELAY cycles after the accept edge (read) or commit edge (write).
// Backpressure: none; commands arriving while BUSY is high are dropped.
module mem_ctr_burst #(
    parameter int LINE_ADDR_W = 10,
    parameter int LINE_BYTES  = 16,
    parameter int BUS_BYTES   = 2,
    parameter int MEM_DELAY   = 100,
    parameter int CNT_W       = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    mem_ctr_burst_if.slave  bus
`ifdef MEM_STATS_EN
    ,
    output logic [CNT_W-1:0] RD_CNT,
    output logic [CNT_W-1:0] WR_CNT,
    output logic [CNT_W-1:0] DROP_CNT
`endif
);
    localparam int BW     = 8 * BUS_BYTES;
    localparam int BEATS  = LINE_BYTES / BUS_BYTES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DLY_W  = $clog2(MEM_DELAY + 1);
    localparam int DEPTH  = 2 ** LINE_ADDR_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [DLY_W-1:0]  DLY_INIT  = DLY_W'(MEM_DELAY);
    localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);
    localparam logic [1:0]        CMD_RESP  = 2'd1;
    localparam logic [1:0]        CMD_RD    = 2'd2;
    localparam logic [1:0]        CMD_WR    = 2'd3;

    typedef logic [BEATS-1:0][BW-1:0] line_t;
    typedef enum logic [2:0] {IDLE, WR_BEATS, WAIT, RD_BEATS, WR_ACK} state_t;

    state_t                 state;
    logic [LINE_ADDR_W-1:0] addr_q;
    logic                   is_wr_q;
    logic [DLY_W-1:0]       dly_q;
    logic [BEAT_W-1:0]      beat_q;
    logic [BEAT_W-1:0]      nxt_beat;
    line_t                  line_q;
    line_t                  commit_line;
    logic                   ram_we;
    logic [LINE_ADDR_W-1:0] ram_waddr;

    // Backing store; deliberately outside reset so contents survive RESET.
    line_t ram [0:DEPTH-1];

    assign nxt_beat = beat_q + 1'b1;

    // The last beat is taken straight from the bus so the whole line lands in one write.
    always_comb begin
        commit_line           = line_q;
        commit_line[BEATS-1]  = bus.D2_IN;
    end

    assign ram_we = !RESET &&
                    (((state == IDLE) && (bus.C2_IN == CMD_WR) && (BEATS == 1)) ||
                     ((state == WR_BEATS) && (beat_q == LAST_BEAT)));
    assign ram_waddr = (state == IDLE) ? bus.A2_IN : addr_q;

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_waddr] <= commit_line;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            dly_q      <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            bus.C2_OUT <= '0;
            bus.D2_OUT <= '0;
            bus.BUSY   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.C2_IN == CMD_RD) begin
                        addr_q   <= bus.A2_IN;
                        is_wr_q  <= 1'b0;
                        dly_q    <= DLY_INIT;
                        state    <= WAIT;
                        bus.BUSY <= 1'b1;
                    end else if (bus.C2_IN == CMD_WR) begin
                        addr_q    <= bus.A2_IN;
                        is_wr_q   <= 1'b1;
                        line_q[0] <= bus.D2_IN;
                        bus.BUSY  <= 1'b1;
                        if (BEATS == 1) begin
                            dly_q <= DLY_INIT;
                            state <= WAIT;
                        end else begin
                            beat_q <= BEAT_W'(1);
                            state  <= WR_BEATS;
                        end
                    end
                end
                WR_BEATS: begin
                    line_q[beat_q] <= bus.D2_IN;
                    if (beat_q == LAST_BEAT) begin
                        dly_q <= DLY_INIT;
                        state <= WAIT;
                    end else begin
                        beat_q <= nxt_beat;
                    end
                end
                WAIT: begin
                    if (dly_q == DLY_ONE) begin
                        bus.C2_OUT <= CMD_RESP;
                        if (is_wr_q) begin
                            bus.D2_OUT <= '0;
                            state      <= WR_ACK;
                        end else begin
                            // Line is snapshotted here, after any earlier commit has landed.
                            line_q     <= ram[addr_q];
                            bus.D2_OUT <= ram[addr_q][0];
                            beat_q     <= '0;
                            state      <= RD_BEATS;
                        end
                    end else begin
                        dly_q <= dly_q - 1'b1;
                    end
                end
                RD_BEATS: begin
                    if (beat_q == LAST_BEAT) begin
                        bus.C2_OUT <= '0;
                        bus.D2_OUT <= '0;
                        bus.BUSY   <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        beat_q     <= nxt_beat;
                        bus.D2_OUT <= line_q[nxt_beat];
                    end
                end
                WR_ACK: begin
                    bus.C2_OUT <= '0;
                    bus.D2_OUT <= '0;
                    bus.BUSY   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus.C2_OUT <= '0;
                    bus.D2_OUT <= '0;
                    bus.BUSY   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    logic acc_rd;
    logic drop;

    assign acc_rd = (state == IDLE) && (bus.C2_IN == CMD_RD);
    assign drop   = bus.BUSY && bus.C2_IN[1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RD_CNT   <= '0;
            WR_CNT   <= '0;
            DROP_CNT <= '0;
        end else begin
            if (acc_rd && (RD_CNT != '1)) begin
                RD_CNT <= RD_CNT + 1'b1;
            end
            if (ram_we && (WR_CNT != '1)) begin
                WR_CNT <= WR_CNT + 1'b1;
            end
            if (drop && (DROP_CNT != '1)) begin
                DROP_CNT <= DROP_CNT + 1'b1;
            end
        end
    end
`endif
endmodule
